// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg : shared types and constants for the hazard/stall unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int   REG_ZERO   = 0;
    localparam int   CNT_W      = 4;
    // Replicated to CTRL_W at the point of use: every control bit of a bubble is 0.
    localparam logic BUBBLE_BIT = 1'b0;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect : combinational load-use hazard comparator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_use_detect
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    output logic              hz_o
);

    // r0 is hardwired to zero, so a load targeting it can never feed a consumer.
    assign hz_o = ex_memread_i
                & (ex_rt_i != REG_AW'(REG_ZERO))
                & ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));

endmodule

`default_nettype wire

// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit : load-use stall / branch flush control, registers ID/EX control.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush cycle counters.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int CTRL_W      = 12,
    parameter int REG_AW      = 5,
    parameter int LOAD_STALL  = 1,
    parameter int FLUSH_SLOTS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              branch_taken,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              bubble
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_cycles
`endif
);

    // The first stall/flush cycle is spent in RUN, so the counter covers the rest.
    localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'((LOAD_STALL  > 1) ? LOAD_STALL  - 2 : 0);
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'((FLUSH_SLOTS > 1) ? FLUSH_SLOTS - 2 : 0);
    localparam logic [CTRL_W-1:0] BUBBLE    = {CTRL_W{BUBBLE_BIT}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [CTRL_W-1:0]  ctrl_q,  ctrl_d;
    logic               bubble_q, bubble_d;
    logic               hz;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_detect (
        .ex_memread_i (ex_memread),
        .ex_rt_i      (ex_rt),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_uses_rt_i (id_uses_rt),
        .hz_o         (hz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            ctrl_q   <= BUBBLE;
            bubble_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            bubble_q <= bubble_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ctrl_d     = BUBBLE;
        bubble_d   = 1'b1;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    ifid_flush = 1'b1;
                    if (FLUSH_SLOTS > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_INIT;
                    end
                end else if (hz) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    if (LOAD_STALL > 1) begin
                        state_d = STALL;
                        cnt_d   = STALL_INIT;
                    end
                end else begin
                    ctrl_d   = ctrl_in;
                    bubble_d = 1'b0;
                end
            end
            STALL: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            FLUSH: begin
                ifid_flush = 1'b1;
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign ctrl_out = ctrl_q;
    assign bubble   = bubble_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_unit : vector table plus multi-cycle sequences for hazard_stall_unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] ctrl_in;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_memread, branch_taken;

    logic [11:0] a_ctrl, b_ctrl;
    logic        a_pw, a_iw, a_fl, a_bub;
    logic        b_pw, b_iw, b_fl, b_bub;
`ifdef HAZARD_STATS_EN
    logic [31:0] a_sc, a_fc, b_sc, b_fc;
`endif

    always #5 clk = ~clk;

    hazard_stall_unit #(.CTRL_W(12), .REG_AW(5), .LOAD_STALL(1), .FLUSH_SLOTS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .branch_taken(branch_taken), .ctrl_out(a_ctrl), .pc_write(a_pw),
        .ifid_write(a_iw), .ifid_flush(a_fl), .bubble(a_bub)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(a_sc), .flush_cycles(a_fc)
`endif
    );

    hazard_stall_unit #(.CTRL_W(12), .REG_AW(5), .LOAD_STALL(3), .FLUSH_SLOTS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .branch_taken(branch_taken), .ctrl_out(b_ctrl), .pc_write(b_pw),
        .ifid_write(b_iw), .ifid_flush(b_fl), .bubble(b_bub)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(b_sc), .flush_cycles(b_fc)
`endif
    );

    typedef struct packed {
        logic [11:0] ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        uses;
        logic        mr;
        logic [4:0]  ext;
        logic        br;
        logic        pw;
        logic        iw;
        logic        fl;
        logic [11:0] q_ctrl;
        logic        q_bub;
    } vec_t;

    typedef struct packed {
        logic [11:0] ctrl;
        logic        bub;
    } sb_t;

    vec_t vecs[10];
    sb_t  sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [11:0] c, input logic [4:0] rs, input logic [4:0] rt,
                         input logic uses, input logic mr, input logic [4:0] ext, input logic br);
        ctrl_in = c; id_rs = rs; id_rt = rt; id_uses_rt = uses;
        ex_memread = mr; ex_rt = ext; branch_taken = br;
    endtask

    task automatic do_reset();
        drive(12'hFFF, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Drive one cycle of stimulus, check DUT B's enables before the edge.
    task automatic b_cycle(input string nm, input logic pw, input logic fl);
        @(negedge clk);
        chk({nm, ".pc_write"},   32'(b_pw), 32'(pw));
        chk({nm, ".ifid_write"}, 32'(b_iw), 32'(pw));
        chk({nm, ".ifid_flush"}, 32'(b_fl), 32'(fl));
        @(posedge clk); #1;
    endtask

    task automatic b_reg(input string nm, input logic [11:0] c, input logic bub);
        chk({nm, ".ctrl_out"}, 32'(b_ctrl), 32'(c));
        chk({nm, ".bubble"},   32'(b_bub),  32'(bub));
    endtask

    initial begin
        //            ctrl    rs  rt  use mr ext br  pw iw fl  q_ctrl  q_bub
        vecs[0] = '{12'hFFF, 5,  0,  0, 1, 5,  0,  0, 0, 0, 12'h000, 1};
        vecs[1] = '{12'h0A5, 5,  0,  0, 0, 5,  0,  1, 1, 0, 12'h0A5, 0};
        vecs[2] = '{12'h123, 0,  0,  0, 1, 0,  0,  1, 1, 0, 12'h123, 0};
        vecs[3] = '{12'h456, 0,  7,  0, 1, 7,  0,  1, 1, 0, 12'h456, 0};
        vecs[4] = '{12'h456, 0,  7,  1, 1, 7,  0,  0, 0, 0, 12'h000, 1};
        vecs[5] = '{12'hFFF, 0,  0,  0, 0, 0,  1,  1, 1, 1, 12'h000, 1};
        vecs[6] = '{12'hFFF, 5,  0,  0, 1, 5,  1,  1, 1, 1, 12'h000, 1};
        vecs[7] = '{12'h3C3, 9,  9,  1, 0, 9,  0,  1, 1, 0, 12'h3C3, 0};
        vecs[8] = '{12'h7E7, 9,  0,  0, 1, 9,  0,  0, 0, 0, 12'h000, 1};
        vecs[9] = '{12'hFFF, 1,  2,  1, 1, 3,  0,  1, 1, 0, 12'hFFF, 0};

        // Reset values with a fully-set control bundle on the input.
        drive(12'hFFF, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst.ctrl_out",   32'(a_ctrl), 32'h0);
        chk("rst.bubble",     32'(a_bub),  32'h1);
        chk("rst.pc_write",   32'(a_pw),   32'h1);
        chk("rst.ifid_write", 32'(a_iw),   32'h1);
        chk("rst.ifid_flush", 32'(a_fl),   32'h0);
        chk("rst.b_ctrl_out", 32'(b_ctrl), 32'h0);
        chk("rst.b_bubble",   32'(b_bub),  32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single-cycle behaviour on the LOAD_STALL=1 / FLUSH_SLOTS=1 instance.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].uses,
                  vecs[i].mr, vecs[i].ext, vecs[i].br);
            sbq.push_back('{ctrl: vecs[i].q_ctrl, bub: vecs[i].q_bub});
            @(negedge clk);
            chk($sformatf("v%0d.pc_write", i),   32'(a_pw), 32'(vecs[i].pw));
            chk($sformatf("v%0d.ifid_write", i), 32'(a_iw), 32'(vecs[i].iw));
            chk($sformatf("v%0d.ifid_flush", i), 32'(a_fl), 32'(vecs[i].fl));
            @(posedge clk); #1;
            if (sbq.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL v%0d.scoreboard: got empty queue, expected an entry", i);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk($sformatf("v%0d.ctrl_out", i), 32'(a_ctrl), 32'(e.ctrl));
                chk($sformatf("v%0d.bubble", i),   32'(a_bub),  32'(e.bub));
            end
        end

        // LOAD_STALL=3: one hazard pulse gives three stall cycles; branch ignored in STALL.
        do_reset();
        drive(12'h0A5, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        b_cycle("ls3.c0", 1'b0, 1'b0);
        b_reg("ls3.c0", 12'h000, 1'b1);
        drive(12'h0A5, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1);
        b_cycle("ls3.c1", 1'b0, 1'b0);
        b_reg("ls3.c1", 12'h000, 1'b1);
        b_cycle("ls3.c2", 1'b0, 1'b0);
        b_reg("ls3.c2", 12'h000, 1'b1);
        drive(12'h0A5, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0);
        b_cycle("ls3.c3", 1'b1, 1'b0);
        b_reg("ls3.c3", 12'h0A5, 1'b0);

        // FLUSH_SLOTS=2: branch wins over a simultaneous hazard, two flush slots.
        do_reset();
        drive(12'h5A5, 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1);
        b_cycle("fl2.c0", 1'b1, 1'b1);
        b_reg("fl2.c0", 12'h000, 1'b1);
        drive(12'h5A5, 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0);
        b_cycle("fl2.c1", 1'b1, 1'b1);
        b_reg("fl2.c1", 12'h000, 1'b1);
        drive(12'h111, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        b_cycle("fl2.c2", 1'b1, 1'b0);
        b_reg("fl2.c2", 12'h111, 1'b0);

        // Async reset in the second cycle of a three-cycle stall.
        do_reset();
        drive(12'h0A5, 5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);
        b_cycle("ar.c0", 1'b0, 1'b0);
        drive(12'h2BC, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        #2;
        chk("ar.pre.pc_write", 32'(b_pw), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("ar.pc_write",   32'(b_pw),   32'h1);
        chk("ar.ifid_write", 32'(b_iw),   32'h1);
        chk("ar.ifid_flush", 32'(b_fl),   32'h0);
        b_reg("ar.rst", 12'h000, 1'b1);
`ifdef HAZARD_STATS_EN
        chk("ar.stall_cycles", b_sc, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        b_cycle("ar.post", 1'b1, 1'b0);
        b_reg("ar.post", 12'h2BC, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Parametrised successor to the ID-stage control-squash mux.
- Detects load-use hazards and registers the ID/EX control bundle.
- Inserts zeroed bubbles (never X) for a configurable number of stall cycles, and flushes IF/ID for a configurable number of slots on a taken branch/jump.
- Sits between the main control decoder and the ID/EX pipeline register; drives PC and IF/ID write enables.

Parameters:
- CTRL_W, 12, width of packed control bundle (pcSrc..SignZero 10 bits + ALUOp 2 bits).
- REG_AW, 5, register-address width.
- LOAD_STALL, 1, bubble cycles per load-use hazard (1..15).
- FLUSH_SLOTS, 1, IF/ID flush cycles per taken branch (1..15).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ctrl_in  in  CTRL_W  decoder control bundle for the instruction in ID.
- id_rs  in  REG_AW  ID source register 1.
- id_rt  in  REG_AW  ID source register 2.
- id_uses_rt  in  1  ID instruction reads rt (R-type, branch, store).
- ex_memread  in  1  instruction in EX is a load.
- ex_rt  in  REG_AW  load destination in EX.
- branch_taken  in  1  EX resolved taken branch or jump.
- ctrl_out  out  CTRL_W  registered control to ID/EX.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID clear to NOP.
- bubble  out  1  registered; ctrl_out this cycle is a bubble.

Behaviour:
- Hazard (combinational): `hz = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)))`.
- FSM states are RUN, STALL and FLUSH. Down-counter `cnt` is 4 bits.
- Reset (async, rst_n=0) sets:
  - state = RUN, cnt = 0, ctrl_out = 0, bubble = 1.
  - pc_write/ifid_write = 1, ifid_flush = 0 (comb from RUN with inputs held inactive).
- RUN, branch_taken=1 (priority over hz):
  - ifid_flush = 1; pc_write = ifid_write = 1.
  - Next: ctrl_out <= 0, bubble <= 1.
  - If FLUSH_SLOTS > 1, go to FLUSH with cnt <= FLUSH_SLOTS-2; otherwise stay in RUN.
- RUN, hz=1, branch_taken=0:
  - pc_write = ifid_write = 0, ifid_flush = 0.
  - Next: ctrl_out <= 0, bubble <= 1.
  - If LOAD_STALL > 1, go to STALL with cnt <= LOAD_STALL-2; otherwise stay in RUN. The held instruction is re-evaluated the next cycle; with the load now in MEM, hz clears.
- RUN otherwise: ctrl_out <= ctrl_in, bubble <= 0, all enables 1, flush 0.
- STALL:
  - pc_write = ifid_write = 0; ctrl_out <= 0, bubble <= 1.
  - cnt==0 -> RUN, else cnt--.
  - branch_taken and hz are ignored (EX holds a bubble).
- FLUSH:
  - ifid_flush = 1, pc_write = ifid_write = 1; ctrl_out <= 0, bubble <= 1.
  - cnt==0 -> RUN, else cnt--.
  - hz is ignored (ID content is being discarded).
- Latency: ctrl_in to ctrl_out is 1 cycle. The write enables and flush are combinational the same cycle.
- Register 0 is never a hazard source.
- rst_n asserted mid-STALL/FLUSH aborts immediately to reset values; the first post-reset edge behaves as RUN.
- Bubble value is all-zero: RegWrite, MemWrite, MemRead, Branch and Jump are all 0.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - Adds ports stall_cycles (out, 32) and flush_cycles (out, 32): saturating counters incremented every cycle pc_write==0, and every cycle ifid_flush==1, respectively.
  - Both counters are cleared by rst_n.
- When undefined: these ports and registers are absent; the block is otherwise identical.

Decomposition:
- Package hazard_pkg:
  - state enum {RUN, STALL, FLUSH}.
  - REG_ZERO constant.
  - CNT_W=4.
  - Localparam-style bubble constant (all zeros, sized by CTRL_W at use).
- Sub-module load_use_detect: pure comparator producing hz; reused by the forwarding unit.
- FSM, counter and output register stay in the top.

Test Plan:
- Reset: rst_n=0 with ctrl_in=12'hFFF -> ctrl_out=0, bubble=1, pc_write=1, ifid_write=1, ifid_flush=0.
- Load-use rs, LOAD_STALL=1: ex_memread=1, ex_rt=5, id_rs=5 -> pc_write=ifid_write=0 for 1 cycle, ctrl_out=0 next edge. Then, with ex_memread=0, ctrl_in=12'h0A5 -> ctrl_out=12'h0A5.
- Zero-register and id_uses_rt gating:
  - ex_rt=0, id_rs=0 -> no stall.
  - ex_rt=7, id_rt=7, id_uses_rt=0 -> no stall.
  - Same with id_uses_rt=1 -> stall.
- Multi-cycle, LOAD_STALL=3: a single hz pulse -> exactly 3 consecutive cycles of pc_write=0 and bubble=1; branch_taken=1 during STALL is ignored.
- Branch priority, FLUSH_SLOTS=2: hz=1 and branch_taken=1 together -> ifid_flush=1 for 2 cycles, pc_write never 0, 2 bubbles.
- rst_n pulsed in the 2nd cycle of a 3-cycle STALL -> immediate return to reset values; stall_cycles (HAZARD_STATS_EN) reads 0.
